// File: rtl/hazard_stall_controller.sv
// Load-use / memory-wait / branch-flush sequencing for the five-stage sail-core pipeline.
// Optional build macro STALL_COUNTER_EN enables the saturating stall_cycles counter.
module hazard_stall_controller #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_nxt;
  logic [2:0] bub_cnt, bub_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       load_use, mem_busy, eval_run;
  logic       ph, ih, iflush, ib, eh, mb;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign mem_busy = mem_req && !mem_ready;

  always_comb begin
    ph = 1'b0; ih = 1'b0; iflush = 1'b0; ib = 1'b0; eh = 1'b0; mb = 1'b0;
    state_nxt = state_q;
    bub_nxt   = bub_cnt;
    wait_nxt  = wait_cnt;
    eval_run  = 1'b0;
    case (state_q)
      RUN: eval_run = 1'b1;
      LOAD_STALL: begin
        // EX holds a bubble here, so a taken-branch indication is meaningless
        if (mem_busy) begin
          ph = 1'b1; ih = 1'b1; eh = 1'b1; mb = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd0;
          bub_nxt   = 3'd0;
        end else begin
          ph = 1'b1; ih = 1'b1; ib = 1'b1;
          bub_nxt = bub_cnt - 3'd1;
          if (bub_cnt <= 3'd1) begin
            state_nxt = RUN;
            bub_nxt   = 3'd0;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          ph = 1'b1; ih = 1'b1; eh = 1'b1; mb = 1'b1;
          if (wait_cnt != TMO) wait_nxt = wait_cnt + 8'd1;
        end else begin
          eval_run = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // Release cycle of MEM_WAIT behaves exactly like RUN
    if (eval_run) begin
      state_nxt = RUN;
      if (mem_busy) begin
        ph = 1'b1; ih = 1'b1; eh = 1'b1; mb = 1'b1;
        state_nxt = MEM_WAIT;
        wait_nxt  = 8'd0;
      end else if (ex_branch_taken) begin
        iflush = 1'b1; ib = 1'b1;
      end else if (load_use) begin
        ph = 1'b1; ih = 1'b1; ib = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt = LOAD_STALL;
          bub_nxt   = 3'(LOAD_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      bub_cnt  <= 3'd0;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      bub_cnt  <= bub_nxt;
      wait_cnt <= wait_nxt;
      if (state_q == MEM_WAIT && mem_busy && wait_nxt == TMO) mem_err <= 1'b1;
    end
  end

  // Inputs may be live during reset; gate controls so reset truly quiesces the pipe
  assign pc_hold      = rst_n & ph;
  assign ifid_hold    = rst_n & ih;
  assign ifid_flush   = rst_n & iflush;
  assign idex_bubble  = rst_n & ib;
  assign exmem_hold   = rst_n & eh;
  assign memwb_bubble = rst_n & mb;
  assign state        = state_q;

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cycles <= '0;
    else if (pc_hold && !(&stall_cycles))   stall_cycles <= stall_cycles + 1'b1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: LOAD_LAT=1 and LOAD_LAT=3 instances share one stimulus stream.
module tb_hazard_stall_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_req, mem_ready;

  logic        ph1, ih1, if1, ib1, eh1, mb1, err1;
  logic        ph3, ih3, if3, ib3, eh3, mb3, err3;
  logic [1:0]  st1, st3;
  logic [31:0] sc1, sc3;
  logic [5:0]  ctl1, ctl3;

  int n_chk = 0;
  int n_err = 0;

  // control vector order: pc_hold ifid_hold ifid_flush idex_bubble exmem_hold memwb_bubble
  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] FREEZE = 6'b110011;
  localparam logic [5:0] LSTALL = 6'b110100;
  localparam logic [5:0] FLUSH  = 6'b001100;

`ifdef STALL_COUNTER_EN
  localparam logic [31:0] SC_EXP = 32'd10;
`else
  localparam logic [31:0] SC_EXP = 32'd0;
`endif

  assign ctl1 = {ph1, ih1, if1, ib1, eh1, mb1};
  assign ctl3 = {ph3, ih3, if3, ib3, eh3, mb3};

  always #5 clk = ~clk;

  hazard_stall_controller #(.LOAD_LAT(1), .MEM_TIMEOUT(15), .CNT_W(32)) d1 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(ph1), .ifid_hold(ih1), .ifid_flush(if1), .idex_bubble(ib1),
    .exmem_hold(eh1), .memwb_bubble(mb1), .state(st1), .mem_err(err1),
    .stall_cycles(sc1));

  hazard_stall_controller #(.LOAD_LAT(3), .MEM_TIMEOUT(15), .CNT_W(32)) d3 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(ph3), .ifid_hold(ih3), .ifid_flush(if3), .idex_bubble(ib3),
    .exmem_hold(eh3), .memwb_bubble(mb3), .state(st3), .mem_err(err3),
    .stall_cycles(sc3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic hazard();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    hazard();
    #1;
    chk("rst_ctl_gated", 32'(ctl1), 32'(NONE));
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(st3), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_cnt", sc1, 32'd0);
    clr();
    rst_n = 1'b1;
    tick();

    // load-use: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 walks 0,1,1,0
    hazard(); #1;
    chk("lu_c0_ctl1", 32'(ctl1), 32'(LSTALL));
    chk("lu_c0_ctl3", 32'(ctl3), 32'(LSTALL));
    chk("lu_c0_st3", 32'(st3), 32'd0);
    tick(); clr(); #1;
    chk("lu_c1_ctl1", 32'(ctl1), 32'(NONE));
    chk("lu_c1_st1", 32'(st1), 32'd0);
    chk("lu_c1_ctl3", 32'(ctl3), 32'(LSTALL));
    chk("lu_c1_st3", 32'(st3), 32'd1);
    tick();
    ex_branch_taken = 1'b1; #1;
    chk("lu_c2_brign", 32'(ctl3), 32'(LSTALL));
    chk("lu_c2_st3", 32'(st3), 32'd1);
    tick(); clr(); #1;
    chk("lu_c3_ctl3", 32'(ctl3), 32'(NONE));
    chk("lu_c3_st3", 32'(st3), 32'd0);

    // register x0 and unused sources never stall; rs2 path does
    hazard(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk("lu_x0", 32'(ctl3), 32'(NONE));
    hazard(); id_use_rs1 = 1'b0; #1;
    chk("lu_unused", 32'(ctl1), 32'(NONE));
    clr(); ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; #1;
    chk("lu_rs2", 32'(ctl1), 32'(LSTALL));
    ex_memread = 1'b0; #1;
    chk("lu_noload", 32'(ctl1), 32'(NONE));
    clr();

    // branch wins over load-use; memory freeze wins over both
    hazard(); ex_branch_taken = 1'b1; #1;
    chk("br_lu_ctl", 32'(ctl3), 32'(FLUSH));
    tick(); clr(); #1;
    chk("br_lu_st3", 32'(st3), 32'd0);
    hazard(); mem_req = 1'b1; #1;
    chk("mem_lu_ctl", 32'(ctl3), 32'(FREEZE));
    tick(); clr(); #1;
    chk("mem_lu_rel", 32'(ctl3), 32'(NONE));
    tick();

    // 4-cycle memory freeze then release
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mw_ctl_%0d", i), 32'(ctl1), 32'(FREEZE));
      chk($sformatf("mw_st_%0d", i), 32'(st1), (i == 0) ? 32'd0 : 32'd2);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("mw_rel_ctl", 32'(ctl1), 32'(NONE));
    chk("mw_rel_st", 32'(st1), 32'd2);
    tick(); clr(); #1;
    chk("mw_run", 32'(st1), 32'd0);

    // mem_busy during LOAD_STALL drops the remaining bubbles
    hazard(); tick(); clr(); mem_req = 1'b1; #1;
    chk("ls_mem_ctl", 32'(ctl3), 32'(FREEZE));
    tick(); #1;
    chk("ls_mem_st", 32'(st3), 32'd2);
    mem_ready = 1'b1; tick(); clr(); #1;
    chk("ls_mem_done", 32'(st3), 32'd0);
    chk("ls_mem_nobub", 32'(ctl3), 32'(NONE));

    // timeout: 20 busy cycles, error visible after the 16th edge
    do_reset();
    mem_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (c == 16) chk("tmo_pre", 32'(err1), 32'd0);
      if (c == 17) chk("tmo_set", 32'(err1), 32'd1);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("tmo_rel_ctl", 32'(ctl1), 32'(NONE));
    tick(); clr(); #1;
    chk("tmo_sticky", 32'(err1), 32'd1);
    do_reset(); #1;
    chk("tmo_clear", 32'(err1), 32'd0);

    // 10 frozen cycles feed the stall counter, then an async reset mid-freeze
    do_reset();
    mem_req = 1'b1;
    repeat (10) tick();
    mem_ready = 1'b1; tick(); clr(); #1;
    chk("cnt_10", sc1, SC_EXP);
    mem_req = 1'b1; tick(); tick(); #1;
    chk("ar_pre", 32'(ctl1), 32'(FREEZE));
    rst_n = 1'b0; #1;
    chk("ar_ctl", 32'(ctl1), 32'(NONE));
    chk("ar_st", 32'(st1), 32'd0);
    chk("ar_cnt", sc1, 32'd0);
    clr();
    @(negedge clk); rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the five-stage sail-core pipeline. Forwarding covers ALU-to-ALU dependences, but loads and multi-cycle data-memory accesses still need the pipeline sequenced. This block detects load-use hazards, inserts a programmable number of bubbles, freezes the whole pipeline while data memory is busy, and flushes the front end on a taken branch. It drives the hold, bubble and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- LOAD_LAT, 1: bubbles inserted per load-use hazard; legal range 1..7.
- MEM_TIMEOUT, 15: number of MEM_WAIT cycles before `mem_err` is set; legal range 1..255.
- CNT_W, 32: width of `stall_cycles`.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- id_rs1, id_rs2  in  5 each  source register addresses of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the instruction in EX is a load.
- ex_branch_taken  in  1  the branch or jump in EX resolved as taken.
- mem_req  in  1  the instruction in MEM accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- ifid_flush  out  1  IF/ID is loaded with a NOP.
- idex_bubble  out  1  ID/EX is loaded with a NOP.
- exmem_hold  out  1  EX/MEM keeps its value.
- memwb_bubble  out  1  MEM/WB is loaded with a NOP.
- state  out  2  current state: RUN=0, LOAD_STALL=1, MEM_WAIT=2. The value 3 is illegal and recovers to RUN on the next edge.
- mem_err  out  1  sticky data-memory timeout flag.
- stall_cycles  out  CNT_W  stall cycle counter (see Configuration).

## Operation
Definitions:
- load_use = ex_memread && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
- mem_busy = mem_req && !mem_ready.

Control outputs are a combinational (Mealy) function of the registered state and the current inputs. Each state asserts its listed controls; all other controls are 0.

RUN state. The first matching case applies:
1. mem_busy: assert pc_hold, ifid_hold, exmem_hold and memwb_bubble. ID/EX holds through the exmem_hold chain; idex_bubble stays 0. Next state is MEM_WAIT and wait_cnt is cleared.
2. ex_branch_taken: assert ifid_flush and idex_bubble. Next state is RUN.
3. load_use: assert pc_hold, ifid_hold and idex_bubble. If LOAD_LAT=1, next state is RUN. Otherwise next state is LOAD_STALL and bub_cnt is loaded with LOAD_LAT-1.
4. Otherwise: no controls asserted.

LOAD_STALL state:
- Asserts pc_hold, ifid_hold and idex_bubble.
- ex_branch_taken is ignored, because EX holds a bubble.
- bub_cnt decrements each cycle. When bub_cnt reaches 1, the next state is RUN.
- If mem_busy occurs, MEM_WAIT controls apply, the next state is MEM_WAIT, and the remaining bubbles are discarded.

MEM_WAIT state:
- While mem_busy: assert the full freeze set (pc_hold, ifid_hold, exmem_hold, memwb_bubble), and wait_cnt increments, saturating at MEM_TIMEOUT.
- When wait_cnt reaches MEM_TIMEOUT, mem_err is set and the block keeps waiting. mem_err clears only on reset.
- On the first cycle with !mem_busy, no freeze is asserted. Branch and load-use are evaluated exactly as in RUN, and the next state is taken from the RUN rules.

Reset:
- While rst_n=0, every control output is 0, state is RUN, bub_cnt=0, wait_cnt=0, mem_err=0 and stall_cycles=0.
- Reset asserted mid-stall aborts the stall immediately, without waiting for a clock edge.

## Timing
- Detection is zero-latency: controls change in the same cycle as the inputs change.
- A load-use hazard produces exactly LOAD_LAT consecutive cycles of idex_bubble=1, provided no memory stall intervenes.
- A memory freeze lasts until the cycle mem_ready=1, and that release cycle is not frozen.
- mem_err rises on the clock edge after the MEM_TIMEOUT-th consecutive busy cycle of MEM_WAIT.
- Simultaneous events resolve in priority order: memory freeze > branch flush > load-use.
- A branch taken together with load_use produces a flush only, with no stall.

## Configuration
STALL_COUNTER_EN:
- Defined: stall_cycles increments on every clock edge where pc_hold=1. It saturates at all-ones and never wraps, and resets to 0.
- Not defined: the counter logic is removed and stall_cycles is tied to 0. The port is present in both builds.

## Test plan
- Load-use with LOAD_LAT=1: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1. Expect one cycle of pc_hold, ifid_hold and idex_bubble, then all 0, state staying 0.
- LOAD_LAT=3 with the same hazard. Expect state sequence 0,1,1,0 and exactly 3 bubble cycles. Repeating with ex_rd=0 gives no stall.
- mem_req=1 and mem_ready low for 4 cycles. Expect freeze controls for 4 cycles, state=2, and release with all controls 0 in the cycle mem_ready=1.
- With MEM_TIMEOUT=15, hold mem_busy for 20 cycles. Expect mem_err=1 from cycle 16 onward, still set after release, and cleared only by rst_n=0.
- Same-cycle ex_branch_taken and load_use. Expect ifid_flush=1, idex_bubble=1 and pc_hold=0. Same-cycle mem_busy and load_use gives the freeze only.
- With STALL_COUNTER_EN defined, run 10 stall cycles. Expect stall_cycles=10. An async reset pulse mid-stall forces all outputs to 0 immediately.
